// File: rtl/ic_remixer.sv
// ic_remixer: rebuilds an N-channel sample x_hat = W * s from one masked C-component IC sample.
// Latency: SIZE_N*SIZE_C + 1 cycles from accept to x_valid; one MAC per cycle.
// Backpressure: result held in OUT until x_ready; s_ready low outside IDLE. Option macro: IC_REMIX_ROUND_EN.
module ic_remixer #(
  parameter int SIZE_N    = 8,
  parameter int SIZE_C    = 3,
  parameter int N_BITS    = 22,
  parameter int FRAC_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_load,
  input  logic [$clog2(SIZE_N)-1:0]  w_row,
  input  logic [$clog2(SIZE_C)-1:0]  w_col,
  input  logic [N_BITS-1:0]          w_data,
  input  logic [SIZE_C-1:0]          comp_mask,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [SIZE_C*N_BITS-1:0]   s_data,
  output logic                       x_valid,
  input  logic                       x_ready,
  output logic [SIZE_N*N_BITS-1:0]   x_data,
  output logic                       sat_flag,
  output logic                       busy
);

  localparam int RW    = $clog2(SIZE_N);
  localparam int CW    = $clog2(SIZE_C);
  localparam int PW    = 2 * N_BITS;
  localparam int ACC_W = PW + CW + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N_BITS+1){1'b0}}, {(N_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N_BITS+1){1'b1}}, {(N_BITS-1){1'b0}}};
`ifdef IC_REMIX_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
`endif

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [N_BITS-1:0]  w_q [SIZE_N][SIZE_C];
  logic signed [N_BITS-1:0]  w_d [SIZE_N][SIZE_C];
  logic signed [N_BITS-1:0]  s_q [SIZE_C];
  logic signed [N_BITS-1:0]  s_d [SIZE_C];
  logic [SIZE_C-1:0]         mask_q, mask_d;
  logic [RW-1:0]             i_q, i_d;
  logic [CW-1:0]             j_q, j_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [N_BITS-1:0]         x_q [SIZE_N];
  logic [N_BITS-1:0]         x_d [SIZE_N];
  logic                      sat_q, sat_d;

  logic signed [N_BITS-1:0]  w_sel, s_sel;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   acc_sum, acc_rnd, acc_shr;
  logic                      sat_hi, sat_lo;
  logic [N_BITS-1:0]         ch_val;

  // Datapath: current product, running sum, and the rounded/shifted/saturated channel value.
  always_comb begin
    w_sel   = w_q[i_q][j_q];
    s_sel   = s_q[j_q];
    prod    = w_sel * s_sel;
    acc_sum = acc_q + (mask_q[j_q] ? {{(ACC_W-PW){prod[PW-1]}}, prod} : '0);
`ifdef IC_REMIX_ROUND_EN
    acc_rnd = acc_sum + RND_HALF;
`else
    acc_rnd = acc_sum;
`endif
    acc_shr = acc_rnd >>> FRAC_BITS;
    sat_hi  = acc_shr > SAT_MAX;
    sat_lo  = acc_shr < SAT_MIN;
    if (sat_hi) begin
      ch_val = SAT_MAX[N_BITS-1:0];
    end else if (sat_lo) begin
      ch_val = SAT_MIN[N_BITS-1:0];
    end else begin
      ch_val = acc_shr[N_BITS-1:0];
    end
  end

  // Next-state and register updates for IDLE -> MAC -> OUT sequencing.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    s_d     = s_q;
    mask_d  = mask_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    x_d     = x_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        // Weight write lands before a same-cycle capture, so the new vector sees it.
        if (w_load && (int'(w_row) < SIZE_N) && (int'(w_col) < SIZE_C)) begin
          w_d[w_row][w_col] = w_data;
        end
        if (s_valid) begin
          for (int k = 0; k < SIZE_C; k++) begin
            s_d[k] = s_data[k*N_BITS +: N_BITS];
          end
          mask_d  = comp_mask;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          sat_d   = 1'b0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (j_q == CW'(SIZE_C - 1)) begin
          x_d[i_q] = ch_val;
          if (sat_hi || sat_lo) begin
            sat_d = 1'b1;
          end
          acc_d = '0;
          j_d   = '0;
          if (i_q == RW'(SIZE_N - 1)) begin
            i_d     = '0;
            state_d = OUT;
          end else begin
            i_d = i_q + RW'(1);
          end
        end else begin
          acc_d = acc_sum;
          j_d   = j_q + CW'(1);
        end
      end
      OUT: begin
        if (x_ready) begin
          sat_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears the weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '{default: '0};
      s_q     <= '{default: '0};
      mask_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      x_q     <= '{default: '0};
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      s_q     <= s_d;
      mask_q  <= mask_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
    end
  end

  // Output decode and channel packing.
  always_comb begin
    s_ready  = (state_q == IDLE);
    x_valid  = (state_q == OUT);
    busy     = (state_q != IDLE);
    sat_flag = sat_q;
    x_data   = '0;
    for (int k = 0; k < SIZE_N; k++) begin
      x_data[k*N_BITS +: N_BITS] = x_q[k];
    end
  end

endmodule
